// File: rtl/lsu_pkt_pkg.sv
// lsu_pkt_pkg: shared opcodes, header field positions and FSM states
// for the LSU memory packetizer.
package lsu_pkt_pkg;

  localparam logic [1:0] PKT_RD     = 2'b01;
  localparam logic [1:0] PKT_WR     = 2'b10;
  localparam logic [1:0] PKT_RD_RSP = 2'b01;
  localparam logic [1:0] PKT_WR_ACK = 2'b10;

  localparam int OP_HI     = 63;
  localparam int OP_LO     = 62;
  localparam int SPACE_BIT = 61;
  localparam int TAG_HI    = 60;
  localparam int TAG_LO    = 54;
  localparam int ADDR_HI   = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_MASK,
    S_WDATA,
    S_RSP_HDR,
    S_RSP_DATA,
    S_ACK
  } state_e;

  function automatic logic [63:0] mk_req_hdr(
    input logic [1:0]  op,
    input logic        space,
    input logic [6:0]  tag,
    input logic [31:0] addr
  );
    logic [63:0] h;
    h                = '0;
    h[OP_HI:OP_LO]   = op;
    h[SPACE_BIT]     = space;
    h[TAG_HI:TAG_LO] = tag;
    h[ADDR_HI:0]     = addr;
    return h;
  endfunction

endpackage

// File: rtl/lsu_mem_packetizer_serdes.sv
// flit_serdes: beat-counted BEATSx64 shift register; shifts write
// data out low beat first and assembles read data low beat first.
module flit_serdes #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] word_i,
  input  logic         clr_i,
  input  logic         shift_out_i,
  input  logic         shift_in_i,
  input  logic [63:0]  flit_i,
  output logic [W-1:0] word_o,
  output logic [63:0]  flit_o,
  output logic         last_o
);

  localparam int BEATS = W / 64;
  localparam int CW    = $clog2(BEATS) + 1;

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // next shift-register contents and beat count
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = word_i;
      cnt_d = '0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (shift_out_i) begin
      sr_d  = sr_q >> 64;
      cnt_d = cnt_q + CW'(1);
    end else if (shift_in_i) begin
      sr_d  = (sr_q >> 64) | (W'(flit_i) << (W - 64));
      cnt_d = cnt_q + CW'(1);
    end
  end

  // shift register and beat counter state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o = sr_q;
  assign flit_o = sr_q[63:0];
  assign last_o = (cnt_q == CW'(BEATS - 1));

endmodule

// File: rtl/lsu_mem_packetizer.sv
// lsu_mem_packetizer: serialises one LSU memory request onto the
// 64-bit filter link and turns the response into a mem_ack pulse.
module lsu_mem_packetizer
  import lsu_pkt_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_rd_en,
  input  logic                        mem_wr_en,
  input  logic                        mem_gm_or_lds,
  input  logic [6:0]                  mem_tag_req,
  input  logic [31:0]                 mem_addr,
  input  logic [63:0]                 mem_wr_mask,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_wr_data,
  output logic                        mem_ack,
  output logic [6:0]                  mem_tag_resp,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_rd_data,
  output logic                        lsu_stall,
  output logic                        lsu_filter_val,
  output logic [63:0]                 lsu_filter_data,
  input  logic                        filter_lsu_rdy,
  input  logic                        filter_lsu_val,
  input  logic [63:0]                 filter_lsu_data,
  output logic                        lsu_filter_rdy,
  output logic                        proto_err
);

  localparam int W     = MEMORY_BUS_WIDTH;
  localparam int BEATS = W / 64;
  localparam int CW    = $clog2(BEATS) + 1;

  state_e        state_q, state_d;
  logic          wr_q;
  logic          space_q;
  logic [6:0]    tag_q;
  logic [31:0]   addr_q;
  logic [63:0]   mask_q;
  logic          err_q, err_d;
  logic          stall_q;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          strobe;
  logic          cap;
  logic          ser_load, ser_clr;
  logic          ser_sout, ser_sin;
  logic [W-1:0]  ser_word;
  logic [63:0]   ser_flit;
  logic          ser_last;
  logic          f_val, f_rdy, ack;
  logic [63:0]   f_data;
  logic [1:0]    rsp_op;
  logic [6:0]    rsp_tag;
  logic          rsp_ok;

  assign strobe  = mem_rd_en | mem_wr_en;
  assign rsp_op  = filter_lsu_data[OP_HI:OP_LO];
  assign rsp_tag = filter_lsu_data[TAG_HI:TAG_LO];
  assign rsp_ok  = (rsp_tag == tag_q) &&
                   (wr_q ? (rsp_op == PKT_WR_ACK)
                         : (rsp_op == PKT_RD_RSP));

  flit_serdes #(
    .W (W)
  ) u_serdes (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ser_load),
    .word_i      (mem_wr_data),
    .clr_i       (ser_clr),
    .shift_out_i (ser_sout),
    .shift_in_i  (ser_sin),
    .flit_i      (filter_lsu_data),
    .word_o      (ser_word),
    .flit_o      (ser_flit),
    .last_o      (ser_last)
  );

  // next state, link handshakes and error/discard bookkeeping
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    drop_d    = drop_q;
    rd_data_d = rd_data_q;
    cap       = 1'b0;
    ser_load  = 1'b0;
    ser_clr   = 1'b0;
    ser_sout  = 1'b0;
    ser_sin   = 1'b0;
    f_val     = 1'b0;
    f_data    = '0;
    f_rdy     = 1'b0;
    ack       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (strobe) begin
          cap      = 1'b1;
          ser_load = 1'b1;
          state_d  = S_HDR;
          if (mem_rd_en && mem_wr_en) err_d = 1'b1;
        end
      end
      S_HDR: begin
        f_val  = 1'b1;
        f_data = mk_req_hdr(wr_q ? PKT_WR : PKT_RD,
                            space_q, tag_q, addr_q);
        if (filter_lsu_rdy) state_d = wr_q ? S_MASK : S_RSP_HDR;
      end
      S_MASK: begin
        f_val  = 1'b1;
        f_data = mask_q;
        if (filter_lsu_rdy) state_d = S_WDATA;
      end
      S_WDATA: begin
        f_val  = 1'b1;
        f_data = ser_flit;
        if (filter_lsu_rdy) begin
          ser_sout = 1'b1;
          if (ser_last) state_d = S_RSP_HDR;
        end
      end
      S_RSP_HDR: begin
        f_rdy = 1'b1;
        if (filter_lsu_val) begin
          if (drop_q != '0) begin
            drop_d = drop_q - CW'(1);
          end else if (rsp_ok) begin
            if (wr_q) begin
              state_d = S_ACK;
            end else begin
              ser_clr = 1'b1;
              state_d = S_RSP_DATA;
            end
          end else begin
            err_d = 1'b1;
            if (rsp_op == PKT_RD_RSP) drop_d = CW'(BEATS);
          end
        end
      end
      S_RSP_DATA: begin
        f_rdy = 1'b1;
        if (filter_lsu_val) begin
          ser_sin = 1'b1;
          if (ser_last) state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack     = 1'b1;
        state_d = S_IDLE;
        if (!wr_q) rd_data_d = ser_word;
      end
      default: state_d = S_IDLE;
    endcase
    if (strobe && (state_q != S_IDLE)) err_d = 1'b1;
  end

  // FSM state, status flags and held read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
      drop_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      stall_q   <= (state_d != S_IDLE);
      drop_q    <= drop_d;
      rd_data_q <= rd_data_d;
    end
  end

  // request fields latched when an idle strobe is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      space_q <= 1'b0;
      tag_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
    end else if (cap) begin
      wr_q    <= mem_wr_en;
      space_q <= mem_gm_or_lds;
      tag_q   <= mem_tag_req;
      addr_q  <= mem_addr;
      mask_q  <= mem_wr_mask;
    end
  end

  assign lsu_filter_val  = f_val;
  assign lsu_filter_data = f_data;
  assign lsu_filter_rdy  = f_rdy;
  assign mem_ack         = ack;
  assign mem_tag_resp    = ack ? tag_q : '0;
  assign mem_rd_data     = (ack && !wr_q) ? ser_word : rd_data_q;
  assign lsu_stall       = stall_q;
  assign proto_err       = err_q;

endmodule

// File: tb/tb_lsu_mem_packetizer.sv
// tb_lsu_mem_packetizer: queue-based transaction model with a
// per-cycle compare, directed cases and randomized traffic.
module tb_lsu_mem_packetizer;

  localparam int W     = 128;
  localparam int BEATS = W / 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_rd_en, mem_wr_en, mem_gm_or_lds;
  logic [6:0]    mem_tag_req;
  logic [31:0]   mem_addr;
  logic [63:0]   mem_wr_mask;
  logic [W-1:0]  mem_wr_data;
  logic          mem_ack;
  logic [6:0]    mem_tag_resp;
  logic [W-1:0]  mem_rd_data;
  logic          lsu_stall;
  logic          lsu_filter_val;
  logic [63:0]   lsu_filter_data;
  logic          filter_lsu_rdy;
  logic          filter_lsu_val;
  logic [63:0]   filter_lsu_data;
  logic          lsu_filter_rdy;
  logic          proto_err;

  lsu_mem_packetizer #(
    .MEMORY_BUS_WIDTH (W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_rd_en       (mem_rd_en),
    .mem_wr_en       (mem_wr_en),
    .mem_gm_or_lds   (mem_gm_or_lds),
    .mem_tag_req     (mem_tag_req),
    .mem_addr        (mem_addr),
    .mem_wr_mask     (mem_wr_mask),
    .mem_wr_data     (mem_wr_data),
    .mem_ack         (mem_ack),
    .mem_tag_resp    (mem_tag_resp),
    .mem_rd_data     (mem_rd_data),
    .lsu_stall       (lsu_stall),
    .lsu_filter_val  (lsu_filter_val),
    .lsu_filter_data (lsu_filter_data),
    .filter_lsu_rdy  (filter_lsu_rdy),
    .filter_lsu_val  (filter_lsu_val),
    .filter_lsu_data (filter_lsu_data),
    .lsu_filter_rdy  (lsu_filter_rdy),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  d;
    bit           last;
    bit           bad;
    bit           upd;
    logic [W-1:0] rdv;
  } rflit_t;

  logic [63:0]  req_q[$];
  rflit_t       rsp_q[$];
  bit           busy, ack_due, exp_err, rdy_exp;
  logic [W-1:0] cur_rd;
  logic [6:0]   ack_tag;
  int           n_checks, n_fail, ack_cnt, cyc;
  int           rdy_mode;
  bit           rsp_rand, junk;

  bit           st_rd, st_wr, st_gm;
  logic [6:0]   st_tag, st_tagx;
  logic [31:0]  st_addr;
  logic [63:0]  st_mask;
  logic [W-1:0] st_wd, st_rdv;
  int           st_bad;

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [63:0] rhdr(input logic [1:0] op,
                                       input logic [6:0] tag);
    logic [63:0] h;
    h        = junk ? {$urandom, $urandom} : 64'h0;
    h[63:62] = op;
    h[60:54] = tag;
    return h;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    req_q.delete();
    rsp_q.delete();
    busy    = 0;
    ack_due = 0;
    exp_err = 0;
    cur_rd  = '0;
    st_rd   = 0;
    st_wr   = 0;
  endtask

  task automatic push_bad(input logic [1:0] op, input logic [6:0] tag);
    rsp_q.push_back('{d: rhdr(op, tag), last: 1'b0, bad: 1'b1,
                      upd: 1'b0, rdv: '0});
    if (op == 2'b01)
      for (int b = 0; b < BEATS; b++)
        rsp_q.push_back('{d: {$urandom, $urandom}, last: 1'b0,
                          bad: 1'b0, upd: 1'b0, rdv: '0});
  endtask

  task automatic accept();
    bit wr;
    wr = st_wr;
    req_q.push_back(((wr ? 64'd2 : 64'd1) << 62) |
                    (64'(st_gm) << 61) | (64'(st_tag) << 54) |
                    64'(st_addr));
    if (wr) begin
      req_q.push_back(st_mask);
      for (int b = 0; b < BEATS; b++) req_q.push_back(st_wd[b*64 +: 64]);
    end
    case (st_bad)
      1:       push_bad(wr ? 2'b10 : 2'b01, st_tag ^ st_tagx);
      2:       push_bad(2'b00, st_tag);
      3:       push_bad(2'b11, st_tag);
      4:       push_bad(wr ? 2'b01 : 2'b10, st_tag);
      default: ;
    endcase
    if (wr) begin
      rsp_q.push_back('{d: rhdr(2'b10, st_tag), last: 1'b1, bad: 1'b0,
                        upd: 1'b0, rdv: '0});
    end else begin
      rsp_q.push_back('{d: rhdr(2'b01, st_tag), last: 1'b0, bad: 1'b0,
                        upd: 1'b0, rdv: '0});
      for (int b = 0; b < BEATS; b++)
        rsp_q.push_back('{d: st_rdv[b*64 +: 64], last: (b == BEATS - 1),
                          bad: 1'b0, upd: 1'b1, rdv: st_rdv});
    end
    ack_tag = st_tag;
    busy    = 1;
  endtask

  task automatic check();
    bit exp_val;
    exp_val = busy && (req_q.size() > 0);
    rdy_exp = busy && (req_q.size() == 0) && !ack_due;
    chk("stall", W'(lsu_stall), W'(busy));
    chk("req_val", W'(lsu_filter_val), W'(exp_val));
    if (exp_val) chk("req_flit", W'(lsu_filter_data), W'(req_q[0]));
    chk("rsp_rdy", W'(lsu_filter_rdy), W'(rdy_exp));
    chk("ack", W'(mem_ack), W'(ack_due));
    if (ack_due) chk("ack_tag", W'(mem_tag_resp), W'(ack_tag));
    chk("rd_data", mem_rd_data, cur_rd);
    chk("proto_err", W'(proto_err), W'(exp_err));
    if (mem_ack) ack_cnt++;
  endtask

  task automatic drive();
    bit     rin, vin, ack_n;
    rflit_t f;
    case (rdy_mode)
      0:       rin = 1'b1;
      1:       rin = cyc[0];
      default: rin = ($urandom_range(0, 2) != 0);
    endcase
    filter_lsu_rdy = rin;
    if (busy && req_q.size() > 0 && rin) void'(req_q.pop_front());
    vin = (rsp_q.size() > 0) && (!rsp_rand || $urandom_range(0, 3) != 0);
    filter_lsu_val  = vin;
    filter_lsu_data = vin ? rsp_q[0].d : {$urandom, $urandom};
    ack_n = 0;
    if (vin && rdy_exp) begin
      f = rsp_q.pop_front();
      if (f.bad) exp_err = 1;
      if (f.last) begin
        ack_n = 1;
        if (f.upd) cur_rd = f.rdv;
      end
    end
    mem_rd_en     = st_rd;
    mem_wr_en     = st_wr;
    mem_gm_or_lds = st_gm;
    mem_tag_req   = st_tag;
    mem_addr      = st_addr;
    mem_wr_mask   = st_mask;
    mem_wr_data   = st_wd;
    if (st_rd || st_wr) begin
      if (busy) begin
        exp_err = 1;
      end else begin
        if (st_rd && st_wr) exp_err = 1;
        accept();
      end
    end
    if (ack_due) busy = 0;
    ack_due = ack_n;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    check();
    drive();
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [6:0] tag,
                       input logic [31:0] addr, input bit gm,
                       input logic [63:0] mask, input logic [W-1:0] wd,
                       input logic [W-1:0] rdv, input int bad,
                       input logic [6:0] tx);
    st_rd   = rd;
    st_wr   = wr;
    st_tag  = tag;
    st_addr = addr;
    st_gm   = gm;
    st_mask = mask;
    st_wd   = wd;
    st_rdv  = rdv;
    st_bad  = bad;
    st_tagx = tx;
    cycle();
    st_rd = 0;
    st_wr = 0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((busy || rsp_q.size() > 0) && n < max) begin
      cycle();
      n++;
    end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL idle_timeout: still busy after %0d cycles", max);
      clear_model();
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    clear_model();
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, a0;
    logic [W-1:0] d;
    bit           rd, wr;
    n_checks = 0;
    n_fail   = 0;
    ack_cnt  = 0;
    cyc      = 0;
    rdy_mode = 0;
    rsp_rand = 0;
    junk     = 0;
    st_gm    = 0;
    st_tag   = '0;
    st_addr  = '0;
    st_mask  = '0;
    st_wd    = '0;
    st_rdv   = '0;
    st_bad   = 0;
    st_tagx  = '0;
    filter_lsu_val  = 0;
    filter_lsu_data = '0;
    filter_lsu_rdy  = 0;
    mem_rd_en = 0;
    mem_wr_en = 0;
    mem_gm_or_lds = 0;
    mem_tag_req = '0;
    mem_addr = '0;
    mem_wr_mask = '0;
    mem_wr_data = '0;
    rst = 1'b0;
    clear_model();
    cycle();
    chk("rst_fdata", W'(lsu_filter_data), W'(0));
    chk("rst_tag", W'(mem_tag_resp), W'(0));
    cycle();
    rst = 1'b1;

    issue(1, 0, 7'h15, 32'h1000, 0, '0, '0,
          {64'hB, 64'hA}, 0, '0);
    cycle();
    chk("rd_hdr_lit", W'(lsu_filter_data), W'(64'h4540_0000_0000_1000));
    lat = 1;
    while (!mem_ack && lat < 20) begin
      cycle();
      lat++;
    end
    chk("rd_latency", W'(lat), W'(3 + BEATS));
    chk("rd_tag_lit", W'(mem_tag_resp), W'(7'h15));
    chk("rd_data_lit", mem_rd_data, {64'hB, 64'hA});
    wait_idle(50);

    rdy_mode = 1;
    a0 = ack_cnt;
    issue(0, 1, 7'h2A, 32'hDEAD_BEEC, 1, {64{1'b1}}, rand_w(),
          '0, 0, '0);
    wait_idle(100);
    chk("wr_one_ack", W'(ack_cnt - a0), W'(1));
    chk("wr_keeps_rd", mem_rd_data, {64'hB, 64'hA});
    rdy_mode = 0;

    reset_dut();
    a0 = ack_cnt;
    d  = rand_w();
    issue(1, 0, 7'h15, 32'h2000, 0, '0, '0, d, 1, 7'h03);
    wait_idle(100);
    chk("badtag_err", W'(proto_err), W'(1));
    chk("badtag_one_ack", W'(ack_cnt - a0), W'(1));
    chk("badtag_data", mem_rd_data, d);

    reset_dut();
    a0 = ack_cnt;
    issue(1, 0, 7'h11, 32'h3000, 1, '0, '0, rand_w(), 0, '0);
    issue(1, 0, 7'h22, 32'h4000, 0, '0, '0, rand_w(), 0, '0);
    wait_idle(100);
    chk("drop_err", W'(proto_err), W'(1));
    chk("drop_one_ack", W'(ack_cnt - a0), W'(1));

    reset_dut();
    issue(1, 1, 7'h33, 32'h5000, 0, 64'h00FF, rand_w(), '0, 0, '0);
    wait_idle(100);
    chk("both_err", W'(proto_err), W'(1));

    reset_dut();
    issue(0, 1, 7'h44, 32'h6000, 0, {64{1'b1}}, rand_w(), '0, 0, '0);
    cycle();
    cycle();
    cycle();
    #2 rst = 1'b0;
    #1;
    chk("arst_val", W'(lsu_filter_val), W'(0));
    chk("arst_data", W'(lsu_filter_data), W'(0));
    chk("arst_rdy", W'(lsu_filter_rdy), W'(0));
    chk("arst_stall", W'(lsu_stall), W'(0));
    chk("arst_ack", W'(mem_ack), W'(0));
    chk("arst_err", W'(proto_err), W'(0));
    clear_model();
    cycle();
    rst = 1'b1;
    a0 = ack_cnt;
    d  = rand_w();
    issue(1, 0, 7'h55, 32'h7000, 0, '0, '0, d, 0, '0);
    wait_idle(100);
    chk("post_rst_ack", W'(ack_cnt - a0), W'(1));
    chk("post_rst_data", mem_rd_data, d);

    junk = 1;
    for (int i = 0; i < 60; i++) begin
      rdy_mode = $urandom_range(0, 2);
      rsp_rand = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      wr = !rd || ($urandom_range(0, 7) == 0);
      issue(rd, wr, 7'($urandom), $urandom, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, rand_w(), rand_w(),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
            7'($urandom_range(1, 127)));
      if ($urandom_range(0, 4) == 0)
        issue(1, 0, 7'($urandom), $urandom, 0, '0, '0, '0, 0, '0);
      wait_idle(300);
    end
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
